iic_cmd_sequencer: RTL and testbench

AXI4-Lite master that drives the AXI IIC core's 9-bit register port to run single-byte I2C register transactions from a simple command handshake. It enables the core after reset, uses dynamic-mode TX_FIFO writes to emit START/address/STOP, polls the status register, and returns read data or an error code. It sits between system logic and the `axi_iic_0_wrapper` slave port.

---
 rtl/iic_cmd_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_iic_cmd_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_cmd_sequencer.sv
// iic_cmd_sequencer: AXI4-Lite master running single-byte I2C register reads/writes
// through the AXI IIC core's dynamic-mode TX_FIFO, with SR polling and timeout recovery.
module iic_cmd_sequencer #(
   parameter int unsigned POLL_LIMIT = 4096,
   parameter logic [31:0] CR_INIT    = 32'h0000_0001
) (
   input  logic        s_axi_aclk,
   input  logic        s_axi_aresetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rnw,
   input  logic [6:0]  cmd_dev,
   input  logic [7:0]  cmd_reg,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic [1:0]  rsp_err,
   output logic [8:0]  m_axi_awaddr,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic [8:0]  m_axi_araddr,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready
);
   typedef enum logic [2:0] {INIT, IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP} state_t;
   localparam logic [15:0] LIMIT = 16'(POLL_LIMIT);

   state_t      state, state_d;
   logic [3:0]  step, step_d;
   logic [15:0] cnt, cnt_d;
   logic        c_rnw;
   logic [6:0]  c_dev;
   logic [7:0]  c_reg, c_wdata;
   logic [1:0]  err_d;
   logic [7:0]  rdata_d;
   logic [9:0]  tx;
   logic [8:0]  op_waddr, op_raddr, awaddr_d, araddr_d;
   logic [31:0] op_wdata, wdata_d;
   logic        accept, b_done, r_done, sr_ok, last_tx, poll_fail_limit;
   logic        awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, rsp_valid_d, cmd_ready_d;
   logic        rdata_unused;

   assign accept          = cmd_valid & cmd_ready;
   assign b_done          = m_axi_bvalid & m_axi_bready;
   assign r_done          = m_axi_rvalid & m_axi_rready;
   assign sr_ok           = c_rnw ? ~m_axi_rdata[6] : m_axi_rdata[7] & ~m_axi_rdata[2];
   assign last_tx         = step == (c_rnw ? 4'd3 : 4'd2);
   assign poll_fail_limit = cnt + 16'd1 == LIMIT;
   assign m_axi_wstrb     = 4'hF;
   assign rdata_unused    = ^m_axi_rdata[31:8];

   // TX_FIFO word: bit8 requests START, bit9 requests STOP
   assign tx       = step == 4'd0 ? {2'b01, c_dev, 1'b0} :
                     step == 4'd1 ? {2'b00, c_reg} :
                     step == 4'd2 ? (c_rnw ? {2'b01, c_dev, 1'b1} : {2'b10, c_wdata}) :
                                    {2'b10, 8'h01};
   assign op_waddr = step == 4'd8 ? 9'h040 : step == 4'd9 ? 9'h100 : 9'h108;
   assign op_wdata = step == 4'd8 ? 32'h0000_000A : step == 4'd9 ? CR_INIT : {22'd0, tx};
   assign op_raddr = step == 4'd5 ? 9'h10C : 9'h104;

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state         <= INIT;
         step          <= '0;
         cnt           <= '0;
         c_rnw         <= 1'b0;
         c_dev         <= '0;
         c_reg         <= '0;
         c_wdata       <= '0;
         rsp_err       <= '0;
         rsp_rdata     <= '0;
         rsp_valid     <= 1'b0;
         cmd_ready     <= 1'b0;
         m_axi_awvalid <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_rready  <= 1'b0;
      end else begin
         state         <= state_d;
         step          <= step_d;
         cnt           <= cnt_d;
         rsp_err       <= err_d;
         rsp_rdata     <= rdata_d;
         rsp_valid     <= rsp_valid_d;
         cmd_ready     <= cmd_ready_d;
         m_axi_awvalid <= awvalid_d;
         m_axi_awaddr  <= awaddr_d;
         m_axi_wvalid  <= wvalid_d;
         m_axi_wdata   <= wdata_d;
         m_axi_bready  <= bready_d;
         m_axi_arvalid <= arvalid_d;
         m_axi_araddr  <= araddr_d;
         m_axi_rready  <= rready_d;
         if (accept) begin
            c_rnw   <= cmd_rnw;
            c_dev   <= cmd_dev;
            c_reg   <= cmd_reg;
            c_wdata <= cmd_wdata;
         end
      end
   end

   // Steps 0..5 are the command micro-ops; 8/9 are SOFTR and CR (CR alone after reset)
   always_comb begin
      state_d = state;
      step_d  = step;
      cnt_d   = cnt;
      err_d   = rsp_err;
      rdata_d = rsp_rdata;
      unique case (state)
         INIT: begin
            state_d = WR_REQ;
            step_d  = 4'd9;
         end
         IDLE: if (accept) begin
            state_d = WR_REQ;
            step_d  = 4'd0;
            err_d   = 2'd0;
            rdata_d = 8'd0;
         end
         WR_REQ: begin
            state_d = WR_RESP;
            cnt_d   = '0;
         end
         WR_RESP: if (b_done) begin
            if (step == 4'd8) begin
               state_d = WR_REQ;
               step_d  = 4'd9;
            end else if (step == 4'd9)
               state_d = rsp_err == 2'd0 ? IDLE : RESP;
            else if (m_axi_bresp != 2'd0) begin
               state_d = RESP;
               err_d   = 2'd1;
            end else begin
               state_d = last_tx ? RD_REQ : WR_REQ;
               step_d  = step + 4'd1;
            end
         end
         RD_REQ: state_d = RD_RESP;
         RD_RESP: if (r_done) begin
            if (m_axi_rresp != 2'd0) begin
               state_d = RESP;
               err_d   = 2'd1;
            end else if (step == 4'd5) begin
               state_d = RESP;
               rdata_d = m_axi_rdata[7:0];
            end else if (sr_ok) begin
               state_d = c_rnw ? RD_REQ : RESP;
               step_d  = 4'd5;
            end else if (poll_fail_limit) begin
               state_d = WR_REQ;
               step_d  = 4'd8;
               err_d   = 2'd2;
            end else begin
               state_d = RD_REQ;
               cnt_d   = cnt + 16'd1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      awvalid_d   = state == WR_REQ || (m_axi_awvalid && !m_axi_awready);
      wvalid_d    = state == WR_REQ || (m_axi_wvalid && !m_axi_wready);
      awaddr_d    = state == WR_REQ ? op_waddr : m_axi_awaddr;
      wdata_d     = state == WR_REQ ? op_wdata : m_axi_wdata;
      bready_d    = state_d == WR_RESP;
      arvalid_d   = state == RD_REQ || (m_axi_arvalid && !m_axi_arready);
      araddr_d    = state == RD_REQ ? op_raddr : m_axi_araddr;
      rready_d    = state_d == RD_RESP;
      rsp_valid_d = state == RESP;
      cmd_ready_d = state_d == IDLE && state != RESP;
   end
endmodule

// File: tb/tb_iic_cmd_sequencer.sv
// tb_iic_cmd_sequencer: scoreboard bench with an AXI4-Lite IIC-core slave model;
// expected AXI transactions and responses are queued by stimulus and popped by a monitor.
module tb_iic_cmd_sequencer;
   typedef struct {logic wr; logic [8:0] addr; logic [31:0] data;} txn_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
   logic [6:0]  cmd_dev = '0;
   logic [7:0]  cmd_reg = '0, cmd_wdata = '0;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic [1:0]  rsp_err;
   logic [8:0]  awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int checks = 0, failures = 0, n_b = 0;
   txn_t exp_q[$];
   logic [9:0] rsp_q[$];

   int aw_dly = 0, w_dly = 0, b_dly = 0, bad_at = 0;
   logic [7:0]  sr_q[$];
   logic [31:0] rx_val = '0;
   int aw_wait, w_wait, b_wait, n_wr;
   logic aw_got, w_got;

   iic_cmd_sequencer #(.POLL_LIMIT(4), .CR_INIT(32'h0000_0001)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_dev(cmd_dev),
      .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Slave model: ready after a programmable wait, B after both beats plus b_dly
   assign awready = awvalid && (aw_wait >= aw_dly);
   assign wready  = wvalid && (w_wait >= w_dly);
   assign arready = arvalid;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_wait <= 0; w_wait <= 0; b_wait <= 0; n_wr <= 0;
         aw_got <= 1'b0; w_got <= 1'b0;
         bvalid <= 1'b0; bresp <= 2'd0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'd0;
      end else begin
         aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
         w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
         if (bvalid && bready) bvalid <= 1'b0;
         if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
            if (b_wait >= b_dly) begin
               bvalid <= 1'b1;
               bresp  <= (n_wr + 1 == bad_at) ? 2'd2 : 2'd0;
               n_wr   <= n_wr + 1;
               aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0;
            end else begin
               b_wait <= b_wait + 1;
               aw_got <= 1'b1; w_got <= 1'b1;
            end
         end else begin
            if (awvalid && awready) aw_got <= 1'b1;
            if (wvalid && wready) w_got <= 1'b1;
         end
         if (rvalid && rready) rvalid <= 1'b0;
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            if (araddr == 9'h104) begin
               rdata <= {24'd0, sr_q[0]};
               if (sr_q.size() > 1) void'(sr_q.pop_front());
            end else
               rdata <= rx_val;
         end
      end
   end

   // Monitor
   logic aw_rec, w_rec, aw_pend, w_pend, ar_pend;
   logic [8:0] got_addr, aw_hold, ar_hold;
   logic [31:0] got_data, w_hold;
   txn_t t;
   logic [9:0] r;

   task automatic pop_cmp(input logic wr, input logic [8:0] addr, input logic [31:0] data);
      if (exp_q.size() == 0) begin
         checks++; failures++;
         $display("FAIL unexpected_txn actual=wr%0d@0x%0h:0x%0h required=none", wr, addr, data);
      end else begin
         t = exp_q.pop_front();
         chk("txn_kind", {31'd0, wr}, {31'd0, t.wr});
         chk("txn_addr", {23'd0, addr}, {23'd0, t.addr});
         if (wr) chk("txn_data", data, t.data);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         aw_rec = 0; w_rec = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
      end else begin
         if (aw_pend) begin chk("aw_hold_v", {31'd0, awvalid}, 1); chk("aw_hold_a", {23'd0, awaddr}, {23'd0, aw_hold}); end
         if (w_pend) begin chk("w_hold_v", {31'd0, wvalid}, 1); chk("w_hold_d", wdata, w_hold); end
         if (ar_pend) begin chk("ar_hold_v", {31'd0, arvalid}, 1); chk("ar_hold_a", {23'd0, araddr}, {23'd0, ar_hold}); end
         aw_pend = awvalid && !awready; aw_hold = awaddr;
         w_pend = wvalid && !wready; w_hold = wdata;
         ar_pend = arvalid && !arready; ar_hold = araddr;
         if (arvalid && (awvalid || wvalid)) begin
            checks++; failures++;
            $display("FAIL ar_aw_overlap actual=both_valid required=exclusive t=%0t", $time);
         end
         if (awvalid && awready) begin aw_rec = 1; got_addr = awaddr; end
         if (wvalid && wready) begin w_rec = 1; got_data = wdata; chk("wstrb", {28'd0, wstrb}, 32'hF); end
         if (aw_rec && w_rec) begin aw_rec = 0; w_rec = 0; pop_cmp(1'b1, got_addr, got_data); end
         if (arvalid && arready) pop_cmp(1'b0, araddr, '0);
         if (bvalid && bready) n_b++;
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_rsp actual=err%0d/0x%0h required=none", rsp_err, rsp_rdata);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_err", {30'd0, rsp_err}, {30'd0, r[9:8]});
               chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, r[7:0]});
            end
         end
      end
   end

   task automatic push_w(input logic [8:0] a, input logic [31:0] d);
      exp_q.push_back('{1'b1, a, d});
   endtask

   task automatic push_r(input logic [8:0] a);
      exp_q.push_back('{1'b0, a, 32'd0});
   endtask

   task automatic wait_ready();
      @(negedge clk);
      for (int i = 0; i < 500 && !cmd_ready; i++) @(negedge clk);
      chk("cmd_ready_wait", {31'd0, cmd_ready}, 1);
   endtask

   task automatic issue(input logic rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
      wait_ready();
      cmd_valid = 1'b1; cmd_rnw = rnw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      chk("cmd_ready_drop", {31'd0, cmd_ready}, 0);
   endtask

   task automatic do_cmd(input logic rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                         input logic [1:0] e, input logic [7:0] d, input int exp_lat);
      int lat;
      rsp_q.push_back({e, d});
      issue(rnw, dev, rg, wd);
      lat = 0;
      while (!rsp_valid && lat < 3000) begin
         @(posedge clk); lat++; #1;
      end
      chk("rsp_seen", {31'd0, rsp_valid}, 1);
      if (exp_lat > 0) chk("latency", lat, exp_lat);
      chk("ready_in_rsp", {31'd0, cmd_ready}, 0);
      @(posedge clk); #1;
      chk("ready_after_rsp", {31'd0, cmd_ready}, 1);
      chk("rsp_hold", {22'd0, rsp_err, rsp_rdata}, {22'd0, e, d});
      chk("txn_drain", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      sr_q = '{8'h80};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valids", {25'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 0);
      chk("rst_addr", {14'd0, awaddr, araddr}, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_rsp", {22'd0, rsp_err, rsp_rdata}, 0);
      push_w(9'h100, 32'h1);
      @(negedge clk) rst_n = 1'b1;
      wait_ready();
      chk("init_b_count", n_b, 1);
      chk("init_drain", exp_q.size(), 0);
      repeat (10) @(negedge clk);
      chk("init_quiet", exp_q.size() + n_b, 1);

      // Write: dev 0x50, reg 0x12, data 0xA5
      sr_q = '{8'h80};
      push_w(9'h108, 32'h1A0); push_w(9'h108, 32'h012); push_w(9'h108, 32'h2A5); push_r(9'h104);
      do_cmd(1'b0, 7'h50, 8'h12, 8'hA5, 2'd0, 8'h00, 13);

      // Read: dev 0x68, reg 0x75, two busy polls
      sr_q = '{8'h40, 8'h40, 8'h00};
      rx_val = 32'h0000_0071;
      push_w(9'h108, 32'h1D0); push_w(9'h108, 32'h075); push_w(9'h108, 32'h1D1); push_w(9'h108, 32'h201);
      push_r(9'h104); push_r(9'h104); push_r(9'h104); push_r(9'h10C);
      do_cmd(1'b1, 7'h68, 8'h75, 8'h00, 2'd0, 8'h71, 0);

      // Backpressure on AW/W/B
      aw_dly = 3; w_dly = 5; b_dly = $urandom_range(1, 4);
      sr_q = '{8'h80};
      push_w(9'h108, 32'h1A0); push_w(9'h108, 32'h012); push_w(9'h108, 32'h2A5); push_r(9'h104);
      do_cmd(1'b0, 7'h50, 8'h12, 8'hA5, 2'd0, 8'h00, 0);
      aw_dly = 0; w_dly = 0; b_dly = 0;

      // Poll timeout with BB stuck
      sr_q = '{8'h04};
      push_w(9'h108, 32'h1A0); push_w(9'h108, 32'h012); push_w(9'h108, 32'h25A);
      for (int i = 0; i < 4; i++) push_r(9'h104);
      push_w(9'h040, 32'hA); push_w(9'h100, 32'h1);
      do_cmd(1'b0, 7'h50, 8'h12, 8'h5A, 2'd2, 8'h00, 0);

      // SLVERR on the second TX_FIFO write
      sr_q = '{8'h80};
      bad_at = n_wr + 2;
      push_w(9'h108, 32'h1A0); push_w(9'h108, 32'h034);
      do_cmd(1'b0, 7'h50, 8'h34, 8'h00, 2'd1, 8'h00, 0);
      repeat (10) @(negedge clk);
      chk("slverr_quiet", exp_q.size(), 0);

      // Reset while AWVALID is held
      aw_dly = 20; w_dly = 20;
      issue(1'b0, 7'h11, 8'h22, 8'h33);
      for (int i = 0; i < 20 && !awvalid; i++) begin @(posedge clk); #1; end
      chk("mid_awvalid", {31'd0, awvalid}, 1);
      #1 rst_n = 1'b0;
      #1 chk("mid_rst_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
      aw_dly = 0; w_dly = 0;
      exp_q.delete();
      push_w(9'h100, 32'h1);
      begin
         int nb0;
         nb0 = n_b;
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         wait_ready();
         chk("reinit_b_count", n_b, nb0 + 1);
      end
      chk("reinit_drain", exp_q.size(), 0);
      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
